// File: rtl/m_axis_rc_skid_check.sv
// RC AXIS register stage: 2-entry skid buffer with registered tready,
// plus a per-packet beat-count checker that flags length and discontinue errors.
module m_axis_rc_skid_check #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rc_tkeep,
  input  logic                  s_axis_rc_tlast,
  input  logic [84:0]           s_axis_rc_tuser,
  input  logic                  s_axis_rc_tvalid,
  output logic [3:0]            s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a,
  output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep_a,
  output logic                  m_axis_rc_tlast_a,
  output logic [84:0]           m_axis_rc_tuser_a,
  output logic                  m_axis_rc_tvalid_a,
  input  logic [3:0]            m_axis_rc_tready_a,
  output logic                  err_len,
  output logic                  err_disc,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 86;

  logic [BW-1:0] w_in;
  logic [BW-1:0] r_m;
  logic [BW-1:0] r_s;
  logic          r_m_valid;
  logic          r_s_valid;
  logic          w_acc;
  logic          w_mxfer;
  logic          w_unused;

  assign w_in = {s_axis_rc_tuser, s_axis_rc_tlast,
                 s_axis_rc_tkeep, s_axis_rc_tdata};
  assign w_acc   = s_axis_rc_tvalid & ~r_s_valid;
  assign w_mxfer = r_m_valid & m_axis_rc_tready_a[0];
  assign w_unused = ^m_axis_rc_tready_a[3:1];

  assign s_axis_rc_tready   = {4{~r_s_valid}};
  assign m_axis_rc_tvalid_a = r_m_valid;
  assign {m_axis_rc_tuser_a, m_axis_rc_tlast_a,
          m_axis_rc_tkeep_a, m_axis_rc_tdata_a} = r_m;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (r_s_valid) begin
      if (w_mxfer) r_s_valid <= 1'b0;
    end else if (w_acc) begin
      if (!r_m_valid || w_mxfer) r_m_valid <= 1'b1;
      else                       r_s_valid <= 1'b1;
    end else if (w_mxfer) begin
      r_m_valid <= 1'b0;
    end
  end

  // payload registers carry no reset; only the valids matter
  always_ff @(posedge user_clk) begin
    if (r_s_valid) begin
      if (w_mxfer) r_m <= r_s;
    end else if (w_acc) begin
      if (!r_m_valid || w_mxfer) r_m <= w_in;
      else                       r_s <= w_in;
    end
  end

  logic        r_body;
  logic        r_supp;
  logic [8:0]  r_exp;
  logic [8:0]  r_bcnt;
  logic [10:0] w_dw2;
  logic [8:0]  w_exp_sop;
  logic [8:0]  w_exp;
  logic [8:0]  w_bcnt;
  logic        w_supp;
  logic        w_len;
  logic        w_disc;

  assign w_dw2     = {1'b0, s_axis_rc_tdata[41:32]} + 11'd2;
  assign w_exp_sop = 9'd1 + w_dw2[10:2];

  always_comb begin
    w_exp  = r_body ? r_exp : w_exp_sop;
    w_bcnt = 9'd1;
    if (r_body)
      w_bcnt = (r_bcnt == 9'h1FF) ? r_bcnt : r_bcnt + 9'd1;
    w_supp = r_body & r_supp;
    w_len  = 1'b0;
    if (w_acc && !w_supp)
      w_len = s_axis_rc_tlast ? (w_bcnt != w_exp)
                              : (w_bcnt == w_exp);
    w_disc = w_acc & s_axis_rc_tuser[42];
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_body   <= 1'b0;
      r_supp   <= 1'b0;
      r_exp    <= '0;
      r_bcnt   <= '0;
      err_len  <= 1'b0;
      err_disc <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err_len  <= w_len;
      err_disc <= w_disc;
      if ((w_len || w_disc) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if (w_acc) begin
        r_exp  <= w_exp;
        r_bcnt <= w_bcnt;
        r_body <= ~s_axis_rc_tlast;
        // one length pulse per packet: mute until tlast
        r_supp <= ~s_axis_rc_tlast & (w_supp | w_len);
      end
    end
  end

endmodule
